// File: rtl/multiword_add_seq.sv
// Word-serial sequencer for a WIDTH-bit combinational adder.
// Adds WORDS-word operands LSW first, chaining carry between words.
module multiword_add_seq #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] in_a,
  input  logic [WIDTH*WORDS-1:0] in_b,
  input  logic                   in_cin,
  output logic [WIDTH-1:0]       adder_a,
  output logic [WIDTH-1:0]       adder_b,
  output logic                   adder_cin,
  input  logic [WIDTH-1:0]       adder_sum,
  input  logic                   adder_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] out_sum,
  output logic                   out_cout
);

  localparam int TW = WIDTH * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   word_idx;
  logic            carry_reg;
  logic [TW-1:0]   a_reg;
  logic [TW-1:0]   b_reg;
  logic [TW-1:0]   sum_reg;
  logic            cout_reg;
  logic            last;

  assign last     = (word_idx == LAST);
  assign out_sum  = sum_reg;
  assign out_cout = cout_reg;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // adder ports are fed only from registers, never from in_*
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        adder_a   = a_reg[word_idx*WIDTH +: WIDTH];
        adder_b   = b_reg[word_idx*WIDTH +: WIDTH];
        adder_cin = carry_reg;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_idx  <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            carry_reg <= in_cin;
            word_idx  <= '0;
          end
        end
        RUN: begin
          sum_reg[word_idx*WIDTH +: WIDTH] <= adder_sum;
          carry_reg <= adder_cout;
          if (last) begin
            cout_reg <= adder_cout;
            word_idx <= '0;
          end else begin
            word_idx <= word_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Bench for multiword_add_seq: WORDS=4 and WORDS=1 instances,
// each attached to a behavioural 32-bit adder.
module tb_multiword_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;

  logic         iv4, ir4, cin4, acin4, acout4, ov4, or4, oc4;
  logic [127:0] a4, b4, os4;
  logic [31:0]  aa4, ab4, as4;

  logic         iv1, ir1, cin1, acin1, acout1, ov1, or1, oc1;
  logic [31:0]  a1, b1, os1;
  logic [31:0]  aa1, ab1, as1;

  assign {acout4, as4} = {1'b0, aa4} + {1'b0, ab4} + {32'd0, acin4};
  assign {acout1, as1} = {1'b0, aa1} + {1'b0, ab1} + {32'd0, acin1};

  multiword_add_seq #(.WIDTH(32), .WORDS(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(iv4), .in_ready(ir4),
    .in_a(a4), .in_b(b4), .in_cin(cin4),
    .adder_a(aa4), .adder_b(ab4), .adder_cin(acin4),
    .adder_sum(as4), .adder_cout(acout4),
    .out_valid(ov4), .out_ready(or4),
    .out_sum(os4), .out_cout(oc4)
  );

  multiword_add_seq #(.WIDTH(32), .WORDS(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(iv1), .in_ready(ir1),
    .in_a(a1), .in_b(b1), .in_cin(cin1),
    .adder_a(aa1), .adder_b(ab1), .adder_cin(acin1),
    .adder_sum(as1), .adder_cout(acout1),
    .out_valid(ov1), .out_ready(or1),
    .out_sum(os1), .out_cout(oc1)
  );

  int total = 0;
  int bad = 0;
  logic [128:0] q4[$];
  logic [32:0]  q1[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [128:0] obs,
                     input logic [128:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [128:0] ref4(input logic [127:0] a,
      input logic [127:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {128'd0, c};
  endfunction

  task automatic run4(input logic [127:0] a, input logic [127:0] b,
                      input logic c, input int stall, input string tag);
    logic [128:0] exp;
    chk({tag, "_inrdy"}, {128'd0, ir4}, 129'd1);
    a4 = a; b4 = b; cin4 = c; iv4 = 1'b1; or4 = 1'b0;
    q4.push_back(ref4(a, b, c));
    step();
    iv4 = 1'b0;
    for (int k = 0; k < 20 && ov4 !== 1'b1; k++) step();
    chk({tag, "_ovalid"}, {128'd0, ov4}, 129'd1);
    exp = q4.pop_front();
    chk({tag, "_sum"}, {oc4, os4}, exp);
    if ({oc4, os4} === exp) $display("PASS %s", tag);
    for (int k = 0; k < stall; k++) step();
    chk({tag, "_hold"}, {oc4, os4}, exp);
    or4 = 1'b1;
    step();
    or4 = 1'b0;
    chk({tag, "_clr"}, {128'd0, ov4}, 129'd0);
  endtask

  task automatic run1(input logic [31:0] a, input logic [31:0] b,
                      input logic c, input int stall, input string tag);
    logic [32:0] exp;
    chk({tag, "_inrdy"}, {128'd0, ir1}, 129'd1);
    a1 = a; b1 = b; cin1 = c; iv1 = 1'b1; or1 = 1'b0;
    q1.push_back({1'b0, a} + {1'b0, b} + {32'd0, c});
    step();
    iv1 = 1'b0;
    for (int k = 0; k < 20 && ov1 !== 1'b1; k++) step();
    chk({tag, "_ovalid"}, {128'd0, ov1}, 129'd1);
    exp = q1.pop_front();
    chk({tag, "_sum"}, {96'd0, oc1, os1}, {96'd0, exp});
    if ({oc1, os1} === exp) $display("PASS %s", tag);
    for (int k = 0; k < stall; k++) step();
    or1 = 1'b1;
    step();
    or1 = 1'b0;
    chk({tag, "_clr"}, {128'd0, ov1}, 129'd0);
  endtask

  // cycle-exact view of one transaction with out_ready held high
  task automatic lat4(input logic [127:0] a, input logic [127:0] b,
                      input logic c, input string tag);
    logic        cy;
    logic [32:0] s;
    logic [128:0] exp;
    chk({tag, "_inrdy"}, {128'd0, ir4}, 129'd1);
    a4 = a; b4 = b; cin4 = c; iv4 = 1'b1; or4 = 1'b1;
    q4.push_back(ref4(a, b, c));
    step();
    iv4 = 1'b0;
    cy = c;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_w%0d_inrdy", tag, i), {128'd0, ir4}, 129'd0);
      chk($sformatf("%s_w%0d_ovalid", tag, i), {128'd0, ov4}, 129'd0);
      chk($sformatf("%s_w%0d_adda", tag, i), {97'd0, aa4},
          {97'd0, a[i*32 +: 32]});
      chk($sformatf("%s_w%0d_addb", tag, i), {97'd0, ab4},
          {97'd0, b[i*32 +: 32]});
      chk($sformatf("%s_w%0d_addcin", tag, i), {128'd0, acin4},
          {128'd0, cy});
      s = {1'b0, a[i*32 +: 32]} + {1'b0, b[i*32 +: 32]} + {32'd0, cy};
      cy = s[32];
      step();
    end
    chk({tag, "_ovalid"}, {128'd0, ov4}, 129'd1);
    exp = q4.pop_front();
    chk({tag, "_sum"}, {oc4, os4}, exp);
    step();
    or4 = 1'b0;
    chk({tag, "_ovalid_low"}, {128'd0, ov4}, 129'd0);
    chk({tag, "_inrdy_back"}, {128'd0, ir4}, 129'd1);
  endtask

  initial begin
    logic [127:0] ra, rb, ones;
    logic [128:0] exp;
    ones = '1;
    rst = 1'b1;
    iv4 = 0; or4 = 0; cin4 = 0; a4 = '0; b4 = '0;
    iv1 = 0; or1 = 0; cin1 = 0; a1 = '0; b1 = '0;
    step();
    step();
    rst = 1'b0;

    chk("rst4_inrdy", {128'd0, ir4}, 129'd1);
    chk("rst4_ovalid", {128'd0, ov4}, 129'd0);
    chk("rst4_sum", {oc4, os4}, 129'd0);
    chk("rst4_adder", {64'd0, acin4, aa4, ab4}, 129'd0);
    chk("rst1_inrdy", {128'd0, ir1}, 129'd1);
    chk("rst1_sum", {96'd0, oc1, os1}, 129'd0);

    lat4(ones, 128'd0, 1'b1, "ripple");
    lat4({32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001},
         {32'h0000_0010, 32'hFFFF_FFFF, 32'h0000_0020, 32'hFFFF_FFFF},
         1'b1, "order");

    run4({4{32'hAAAA_AAAA}}, {4{32'h5555_5555}}, 1'b0, 0, "alt0");
    run4({4{32'hAAAA_AAAA}}, {4{32'h5555_5555}}, 1'b1, 2, "alt1");

    // backpressure: DONE must ignore new operands and hold its result
    chk("bp_inrdy", {128'd0, ir4}, 129'd1);
    a4 = {4{32'h1234_5678}}; b4 = {4{32'h8765_4321}}; cin4 = 1'b1;
    iv4 = 1'b1; or4 = 1'b0;
    q4.push_back(ref4(a4, b4, cin4));
    step();
    iv4 = 1'b0;
    for (int k = 0; k < 20 && ov4 !== 1'b1; k++) step();
    chk("bp_ovalid", {128'd0, ov4}, 129'd1);
    exp = q4.pop_front();
    chk("bp_sum", {oc4, os4}, exp);
    for (int k = 0; k < 10; k++) begin
      iv4 = k[0];
      a4 = {$urandom, $urandom, $urandom, $urandom};
      b4 = {$urandom, $urandom, $urandom, $urandom};
      cin4 = 1'(k);
      step();
      chk($sformatf("bp_hold_valid%0d", k), {128'd0, ov4}, 129'd1);
      chk($sformatf("bp_hold_sum%0d", k), {oc4, os4}, exp);
      chk($sformatf("bp_hold_inrdy%0d", k), {128'd0, ir4}, 129'd0);
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    step();
    or4 = 1'b0;
    chk("bp_clr_valid", {128'd0, ov4}, 129'd0);
    chk("bp_clr_inrdy", {128'd0, ir4}, 129'd1);
    step();
    chk("bp_no_capture", {128'd0, ir4}, 129'd1);

    // reset at word_idx 2 with a carry pending
    a4 = ones; b4 = '0; cin4 = 1'b1; iv4 = 1'b1;
    step();
    iv4 = 1'b0;
    step();
    step();
    chk("mid_carry", {128'd0, acin4}, 129'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_inrdy", {128'd0, ir4}, 129'd1);
    chk("mid_ovalid", {128'd0, ov4}, 129'd0);
    chk("mid_sum", {oc4, os4}, 129'd0);
    run4(128'd0, 128'd0, 1'b0, 0, "after_rst");

    for (int n = 0; n < 50; n++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      if (n % 10 == 0) ra = ones;
      run4(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
           $sformatf("rnd4_%0d", n));
    end
    for (int n = 0; n < 50; n++) begin
      run1($urandom, (n % 10 == 0) ? 32'hFFFF_FFFF : $urandom,
           1'($urandom_range(0, 1)), $urandom_range(0, 3),
           $sformatf("rnd1_%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
